// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, response and ALU signal bundle for alu_share_arbiter.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_data1, req0_data2, req1_data1, req1_data2;
    logic [3:0]       req0_ctrl, req1_ctrl;
    logic [31:0]      req0_imm, req1_imm;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [WIDTH-1:0] resp_result;
    logic             resp_err;
    logic [WIDTH-1:0] alu_data1, alu_data2;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_imm;
    logic [WIDTH-1:0] alu_result;

    modport master (
        output req_valid, req0_data1, req0_data2, req1_data1, req1_data2,
               req0_ctrl, req1_ctrl, req0_imm, req1_imm, resp_ready, alu_result,
        input  req_ready, resp_valid, resp_result, resp_err,
               alu_data1, alu_data2, alu_ctrl, alu_imm
    );

    modport slave (
        input  req_valid, req0_data1, req0_data2, req1_data1, req1_data2,
               req0_ctrl, req1_ctrl, req0_imm, req1_imm, resp_ready, alu_result,
        output req_ready, resp_valid, resp_result, resp_err,
               alu_data1, alu_data2, alu_ctrl, alu_imm
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU between two requesters.
// Define ALU_ARB_OPCHECK_EN to answer illegal opcodes directly with resp_err instead of running them.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q;
    logic             last_q, owner_q, err_q;
    logic [1:0]       resp_valid_q;
    logic [WIDTH-1:0] data1_q, data2_q, result_q;
    logic [3:0]       ctrl_q;
    logic [31:0]      imm_q;
    logic [1:0]       grant;
    logic             sel, bad;
    logic [WIDTH-1:0] data1_d, data2_d;
    logic [3:0]       ctrl_d;
    logic [31:0]      imm_d;

    always_comb begin
        grant   = &bus.req_valid ? (last_q ? 2'b01 : 2'b10) : bus.req_valid;
        sel     = grant[1];
        data1_d = sel ? bus.req1_data1 : bus.req0_data1;
        data2_d = sel ? bus.req1_data2 : bus.req0_data2;
        ctrl_d  = sel ? bus.req1_ctrl : bus.req0_ctrl;
        imm_d   = sel ? bus.req1_imm : bus.req0_imm;
    end

`ifdef ALU_ARB_OPCHECK_EN
    assign bad = !(ctrl_d inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1000, 4'b1001, 4'b1010});
`else
    assign bad = 1'b0;
`endif

    // Ready is held low while reset is asserted so nothing looks accepted during reset.
    assign bus.req_ready   = (rst_n && state_q == IDLE) ? grant : 2'b00;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign bus.resp_err    = err_q;
    assign bus.alu_data1   = data1_q;
    assign bus.alu_data2   = data2_q;
    assign bus.alu_ctrl    = ctrl_q;
    assign bus.alu_imm     = imm_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            err_q        <= 1'b0;
            resp_valid_q <= 2'b00;
            data1_q      <= '0;
            data2_q      <= '0;
            result_q     <= '0;
            ctrl_q       <= '0;
            imm_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (|grant) begin
                    data1_q      <= data1_d;
                    data2_q      <= data2_d;
                    ctrl_q       <= ctrl_d;
                    imm_q        <= imm_d;
                    owner_q      <= sel;
                    result_q     <= '0;
                    err_q        <= bad;
                    resp_valid_q <= bad ? grant : 2'b00;
                    state_q      <= bad ? RESP : EXEC;
                end
                EXEC: begin
                    result_q     <= bus.alu_result;
                    err_q        <= 1'b0;
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: if (bus.resp_ready[owner_q]) begin
                    resp_valid_q <= 2'b00;
                    last_q       <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks against a transaction-level model.
// Expectations follow ALU_ARB_OPCHECK_EN when the bench is built with it.
module tb_alu_share_arbiter;
    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
    } op_t;

`ifdef ALU_ARB_OPCHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    alu_share_arbiter_if #(.WIDTH(32)) bus();
    alu_share_arbiter #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(op_t o);
        logic [31:0] s;
        s = {{20{o.imm[11]}}, o.imm[11:0]};
        case (o.ctrl)
            4'b0000: return o.d1 & o.d2;
            4'b0001: return o.d1 | o.d2;
            4'b0010: return o.d1 + o.d2;
            4'b0110: return o.d1 - o.d2;
            4'b1000: return o.d1 + s;
            4'b1001: return o.d1 & s;
            4'b1010: return o.d1 | s;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit legal(logic [3:0] c);
        return c inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd8, 4'd9, 4'd10};
    endfunction

    assign bus.alu_result = alu_ref(op_t'({bus.alu_ctrl, bus.alu_data1, bus.alu_data2, bus.alu_imm}));

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    op_t         q0[$], q1[$];
    bit          busy = 0, own = 0, eerr = 0, mlast = 1, post_rst = 1;
    bit          rr_rand = 0, auto_push = 0;
    logic [1:0]  rr_force = 2'b11;
    int          age = 0, lat = 2, handshakes = 0;
    logic [31:0] eres = '0;
    op_t         aop = '0;
    bit          log_own[$], log_err[$];
    logic [31:0] log_res[$];

    function automatic op_t rand_op();
        logic [3:0] codes [7] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd8, 4'd9, 4'd10};
        op_t o;
        o.ctrl = ($urandom_range(0, 7) == 0) ? 4'($urandom) : codes[$urandom_range(0, 6)];
        o.d1   = $urandom;
        o.d2   = $urandom;
        o.imm  = $urandom;
        return o;
    endfunction

    function automatic op_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [31:0] i);
        op_t o;
        o.ctrl = c; o.d1 = a; o.d2 = b; o.imm = i;
        return o;
    endfunction

    task automatic drive_req();
        bus.req_valid  = {q1.size() != 0, q0.size() != 0};
        bus.req0_ctrl  = q0.size() ? q0[0].ctrl : 4'($urandom);
        bus.req0_data1 = q0.size() ? q0[0].d1 : $urandom;
        bus.req0_data2 = q0.size() ? q0[0].d2 : $urandom;
        bus.req0_imm   = q0.size() ? q0[0].imm : $urandom;
        bus.req1_ctrl  = q1.size() ? q1[0].ctrl : 4'($urandom);
        bus.req1_data1 = q1.size() ? q1[0].d1 : $urandom;
        bus.req1_data2 = q1.size() ? q1[0].d2 : $urandom;
        bus.req1_imm   = q1.size() ? q1[0].imm : $urandom;
    endtask

    // One cycle: check outputs at the falling edge, drive new inputs, predict the next rising edge.
    task automatic step(bit r);
        logic [1:0] g;
        bit         ill;
        @(negedge clk);
        if (busy) age++;
        check("resp_valid", bus.resp_valid, (busy && age >= lat) ? (own ? 2'b10 : 2'b01) : 2'b00);
        if (busy && age >= lat) begin
            check("resp_result", bus.resp_result, eres);
            check("resp_err", bus.resp_err, eerr);
        end
        if (post_rst) begin
            check("result_after_rst", bus.resp_result, 0);
            check("err_after_rst", bus.resp_err, 0);
        end
        check("alu_ops", {bus.alu_ctrl, bus.alu_data1, bus.alu_data2, bus.alu_imm}, aop);
        if (auto_push) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_op());
            if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_op());
        end
        rst_n = r;
        drive_req();
        bus.resp_ready = rr_rand ? 2'($urandom) : rr_force;
        #1;
        if (!rst_n) begin
            check("req_ready_rst", bus.req_ready, 0);
            busy = 0; mlast = 1; aop = '0; post_rst = 1;
        end else if (!busy) begin
            g = (q0.size() && q1.size()) ? (mlast ? 2'b01 : 2'b10) : {q1.size() != 0, q0.size() != 0};
            check("req_ready", bus.req_ready, g);
            if (g != 2'b00) begin
                own  = g[1];
                aop  = own ? q1.pop_front() : q0.pop_front();
                ill  = CHK && !legal(aop.ctrl);
                busy = 1; age = 0; post_rst = 0;
                lat  = ill ? 1 : 2;
                eres = ill ? 32'd0 : alu_ref(aop);
                eerr = ill;
            end
        end else begin
            check("req_ready_busy", bus.req_ready, 0);
            if (age >= lat && bus.resp_ready[own]) begin
                log_own.push_back(own);
                log_res.push_back(bus.resp_result);
                log_err.push_back(bus.resp_err);
                busy = 0; mlast = own; handshakes++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || q0.size() != 0 || q1.size() != 0) && n < 300) begin
            step(1);
            n++;
        end
        check("drain_idle", {busy, q0.size() != 0, q1.size() != 0}, 0);
        step(1);
    endtask

    task automatic clear_logs();
        log_own.delete();
        log_res.delete();
        log_err.delete();
    endtask

    initial begin
        int h0;
        bus.req_valid  = 2'b00;
        bus.resp_ready = 2'b00;
        drive_req();
        step(0);
        step(0);
        q0.push_back(mk(4'b0010, 32'd5, 32'd7, 32'd0));
        drain();
        check("add_5_7", log_res[0], 32'd12);

        step(0);
        clear_logs();
        q0.push_back(mk(4'b0110, 32'd10, 32'd3, 32'd0));
        q1.push_back(mk(4'b1000, 32'd1, 32'd0, 32'h00F));
        drain();
        q0.push_back(mk(4'b0110, 32'd10, 32'd3, 32'd0));
        q1.push_back(mk(4'b1000, 32'd1, 32'd0, 32'h00F));
        drain();
        check("contend_order", {log_own[0], log_own[1], log_own[2], log_own[3]}, 4'b0101);
        check("contend_sub", log_res[0], 32'd7);
        check("contend_addi", log_res[1], 32'd16);

        q0.push_back(mk(4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd0));
        q1.push_back(rand_op());
        rr_force = 2'b10;
        repeat (8) step(1);
        rr_force = 2'b11;
        drain();

        h0 = handshakes;
        q0.push_back(mk(4'b0001, 32'hF0, 32'h0F, 32'd0));
        step(1);
        step(1);
        step(0);
        step(1);
        check("no_resp_after_rst", handshakes, h0);
        clear_logs();
        q1.push_back(mk(4'b1001, 32'hABCD, 32'd0, 32'hFFF));
        drain();
        check("after_rst_andi", log_res[0], 32'hABCD);

        clear_logs();
        q0.push_back(mk(4'b1111, 32'd9, 32'd4, 32'd3));
        drain();
        check("illegal_res", log_res[0], 32'd0);
        check("illegal_err", log_err[0], CHK);

        auto_push = 1;
        rr_rand = 1;
        repeat (400) step(1);
        auto_push = 0;
        rr_rand = 0;
        rr_force = 2'b11;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad %0d", n_bad);
        $fatal(1);
    end
endmodule
